// File: rtl/crypt_cbc_seq.sv
// Sequential toy block cipher with CBC/ECB chaining over an M-block message.
// One cipher round per clock. The full result is registered when the last
// round completes, then presented for one DONE cycle with ap_done/ap_ready.
module crypt_cbc_seq #(
    parameter int unsigned W = 16,  // block width in bits (>= 2)
    parameter int unsigned M = 4,   // blocks per message (>= 1)
    parameter int unsigned N = 2    // cipher rounds per block (>= 1)
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    input  logic           ap_start,
    input  logic           encrypt_decrypt,
    input  logic           chain_en,
    input  logic [W-1:0]   key,
    input  logic [W-1:0]   iv,
    input  logic [M*W-1:0] message,
    output logic           ap_done,
    output logic           ap_idle,
    output logic           ap_ready,
    output logic [M*W-1:0] ap_return
);

    localparam int unsigned BW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [M*W-1:0] msg_q, msg_d;    // captured input blocks (ciphertext kept for CBC decrypt)
    logic [W-1:0]   key_q, key_d;
    logic           dec_q, dec_d;
    logic           chain_q, chain_d;
    logic [W-1:0]   x_q, x_d;        // working value of the current block
    logic [W-1:0]   prev_q, prev_d;  // previous ciphertext block, used by decrypt
    logic [M*W-1:0] res_q, res_d;    // result blocks assembled so far
    logic [M*W-1:0] ret_q, ret_d;
    logic [BW-1:0]  blk_q, blk_d;
    logic [RW-1:0]  rnd_q, rnd_d;

    function automatic logic [W-1:0] enc_round(input logic [W-1:0] x, input logic [W-1:0] k,
                                               input logic [W-1:0] r);
        logic [W-1:0] t;
        t = x ^ k;
        return {t[W-2:0], t[W-1]} + r;
    endfunction

    function automatic logic [W-1:0] dec_round(input logic [W-1:0] x, input logic [W-1:0] k,
                                               input logic [W-1:0] r);
        logic [W-1:0] t;
        t = x - r;
        return {t[0], t[W-1:1]} ^ k;
    endfunction

    // Next-state: operand capture on accept, one round per RUN cycle, chaining between blocks
    always_comb begin
        logic [W-1:0] rnd_val;
        logic [W-1:0] y;
        logic [W-1:0] blk_out;
        logic [W-1:0] nxt;
        int unsigned  nb;

        state_d = state_q;
        msg_d   = msg_q;
        key_d   = key_q;
        dec_d   = dec_q;
        chain_d = chain_q;
        x_d     = x_q;
        prev_d  = prev_q;
        res_d   = res_q;
        ret_d   = ret_q;
        blk_d   = blk_q;
        rnd_d   = rnd_q;
        rnd_val = '0;
        y       = '0;
        blk_out = '0;
        nxt     = '0;
        nb      = 0;

        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    msg_d   = message;
                    key_d   = key;
                    dec_d   = encrypt_decrypt;
                    chain_d = chain_en;
                    // Encrypt folds the IV into block 0 up front; decrypt applies it afterwards.
                    x_d     = message[W-1:0] ^ ((chain_en && !encrypt_decrypt) ? iv : '0);
                    prev_d  = iv;
                    res_d   = '0;
                    blk_d   = '0;
                    rnd_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Decrypt walks the round constants in reverse order.
                if (dec_q) rnd_val = W'(N - 1 - int'(rnd_q));
                else       rnd_val = W'(int'(rnd_q));
                y     = dec_q ? dec_round(x_q, key_q, rnd_val) : enc_round(x_q, key_q, rnd_val);
                x_d   = y;
                rnd_d = rnd_q + RW'(1);
                if (rnd_q == RW'(N - 1)) begin
                    blk_out = dec_q ? (y ^ (chain_q ? prev_q : '0)) : y;
                    res_d[int'(blk_q)*W +: W] = blk_out;
                    prev_d = msg_q[int'(blk_q)*W +: W];
                    rnd_d  = '0;
                    if (blk_q == BW'(M - 1)) begin
                        ret_d   = res_d;
                        state_d = StDone;
                    end else begin
                        nb    = int'(blk_q) + 1;
                        nxt   = msg_q[nb*W +: W];
                        blk_d = blk_q + BW'(1);
                        x_d   = dec_q ? nxt : (nxt ^ (chain_q ? y : '0));
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
            msg_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
            chain_q <= 1'b0;
            x_q     <= '0;
            prev_q  <= '0;
            res_q   <= '0;
            ret_q   <= '0;
            blk_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
            chain_q <= chain_d;
            x_q     <= x_d;
            prev_q  <= prev_d;
            res_q   <= res_d;
            ret_q   <= ret_d;
            blk_q   <= blk_d;
            rnd_q   <= rnd_d;
        end
    end

    // Handshake outputs decoded from the state
    always_comb begin
        ap_idle   = (state_q == StIdle);
        ap_done   = (state_q == StDone);
        ap_ready  = (state_q == StDone);
        ap_return = ret_q;
    end

endmodule

// File: tb/tb_crypt_cbc_seq.sv
// Directed and randomised bench for crypt_cbc_seq at W=16, M=4, N=2.
module tb_crypt_cbc_seq;

    localparam int unsigned W = 16;
    localparam int unsigned M = 4;
    localparam int unsigned N = 2;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           ap_start = 1'b0;
    logic           encrypt_decrypt = 1'b0;
    logic           chain_en = 1'b0;
    logic [W-1:0]   key = '0;
    logic [W-1:0]   iv = '0;
    logic [M*W-1:0] message = '0;
    logic           ap_done;
    logic           ap_idle;
    logic           ap_ready;
    logic [M*W-1:0] ap_return;

    int n_checks = 0;
    int n_fail   = 0;

    crypt_cbc_seq #(
        .W(W),
        .M(M),
        .N(N)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .encrypt_decrypt (encrypt_decrypt),
        .chain_en        (chain_en),
        .key             (key),
        .iv              (iv),
        .message         (message),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .ap_return       (ap_return)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model straight from the round definitions
    function automatic logic [15:0] e_blk(input logic [15:0] x, input logic [15:0] k);
        logic [15:0] t;
        for (int r = 0; r < 2; r++) begin
            t = x ^ k;
            x = {t[14:0], t[15]} + 16'(r);
        end
        return x;
    endfunction

    function automatic logic [15:0] d_blk(input logic [15:0] x, input logic [15:0] k);
        logic [15:0] t;
        for (int r = 1; r >= 0; r--) begin
            t = x - 16'(r);
            x = {t[0], t[15:1]} ^ k;
        end
        return x;
    endfunction

    function automatic logic [63:0] model(input logic dec, input logic chain,
                                          input logic [15:0] k, input logic [15:0] v,
                                          input logic [63:0] m);
        logic [63:0] out;
        logic [15:0] prev, b, o;
        out  = '0;
        prev = v;
        for (int i = 0; i < 4; i++) begin
            b = m[i*16 +: 16];
            if (!dec) begin
                o    = e_blk(b ^ (chain ? prev : 16'h0), k);
                prev = o;
            end else begin
                o    = d_blk(b, k) ^ (chain ? prev : 16'h0);
                prev = b;
            end
            out[i*16 +: 16] = o;
        end
        return out;
    endfunction

    // One operation: wait for idle, accept, scramble inputs, wait for done (bounded)
    task automatic run_op(input logic dec, input logic chain, input logic [15:0] k,
                          input logic [15:0] v, input logic [63:0] m,
                          output logic [63:0] res, output int lat);
        int guard;
        @(negedge ap_clk);
        guard = 0;
        while (!ap_idle && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        encrypt_decrypt = dec;
        chain_en        = chain;
        key             = k;
        iv              = v;
        message         = m;
        ap_start        = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start        = 1'b0;
        message         = ~m;
        key             = ~k;
        iv              = ~v;
        encrypt_decrypt = ~dec;
        chain_en        = ~chain;
        lat = 0;
        do begin
            @(posedge ap_clk);
            #1;
            lat++;
        end while (!ap_done && lat < 50);
        check_eq("done_pulse", 64'(ap_done), 64'd1);
        res = ap_return;
    endtask

    initial begin
        logic [63:0] res, res2, m, exp, mv;
        logic [15:0] k, v;
        int          lat, guard, last_acc, n_res, seen;
        int          acc_q[$];
        logic [63:0] msg_q[$];

        // Reset, with ap_start asserted alongside to show reset wins
        ap_start = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        check_eq("rst_idle", 64'(ap_idle), 64'd1);
        check_eq("rst_done", 64'(ap_done), 64'd0);
        check_eq("rst_ready", 64'(ap_ready), 64'd0);
        check_eq("rst_return", ap_return, 64'h0);
        ap_start = 1'b0;
        ap_rst   = 1'b0;

        // CBC encrypt of zeros, with latency
        run_op(1'b0, 1'b1, 16'h0, 16'h0, 64'h0, res, lat);
        check_eq("cbc_enc_zero", res, 64'h0055_0015_0005_0001);
        check_eq("cbc_enc_latency", 64'(lat), 64'd8);
        check_eq("ready_with_done", 64'(ap_ready), 64'd1);
        @(posedge ap_clk);
        #1;
        check_eq("return_hold", ap_return, 64'h0055_0015_0005_0001);
        check_eq("done_one_cycle", 64'(ap_done), 64'd0);
        check_eq("idle_after_done", 64'(ap_idle), 64'd1);

        // CBC decrypt back to zeros
        run_op(1'b1, 1'b1, 16'h0, 16'h0, 64'h0055_0015_0005_0001, res, lat);
        check_eq("cbc_dec_zero", res, 64'h0);

        // ECB ignores the IV
        run_op(1'b0, 1'b0, 16'h0, 16'hFFFF, 64'h0, res, lat);
        check_eq("ecb_enc_iv_ignored", res, 64'h0001_0001_0001_0001);

        // Nonzero key, ECB: E(0) with key 1 is 7
        run_op(1'b0, 1'b0, 16'h0001, 16'h0, 64'h0, res, lat);
        check_eq("ecb_enc_key1", res, 64'h0007_0007_0007_0007);
        run_op(1'b1, 1'b0, 16'h0001, 16'hBEEF, 64'h0007_0007_0007_0007, res, lat);
        check_eq("ecb_dec_key1", res, 64'h0);

        // MSB wraps through the rotate: E(8000) = 3
        run_op(1'b0, 1'b0, 16'h0, 16'h0, 64'h0000_0000_0000_8000, res, lat);
        check_eq("ecb_rotl_wrap", res, 64'h0001_0001_0001_0003);

        // Reset mid-operation (reset sampled at E4)
        @(negedge ap_clk);
        guard = 0;
        while (!ap_idle && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        encrypt_decrypt = 1'b0;
        chain_en        = 1'b1;
        key             = 16'h1111;
        iv              = 16'h2222;
        message         = 64'h0123_4567_89AB_CDEF;
        ap_start        = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        seen = (ap_done === 1'b1) ? 1 : 0;
        repeat (20) begin
            @(posedge ap_clk);
            #1;
            if (ap_done) seen = 1;
        end
        check_eq("rst_mid_no_done", 64'(seen), 64'd0);
        check_eq("rst_mid_idle", 64'(ap_idle), 64'd1);
        check_eq("rst_mid_return", ap_return, 64'h0);

        // Back-to-back with ap_start held and message changing every cycle
        @(negedge ap_clk);
        encrypt_decrypt = 1'b0;
        chain_en        = 1'b1;
        key             = 16'h1234;
        iv              = 16'h0F0F;
        ap_start        = 1'b1;
        last_acc        = -1;
        n_res           = 0;
        for (int c = 0; c < 42; c++) begin
            if (c > 0) @(negedge ap_clk);
            if (ap_done) begin
                if (msg_q.size() == 0) begin
                    check_eq("b2b_spurious_done", 64'(ap_done), 64'd0);
                end else begin
                    exp = model(1'b0, 1'b1, 16'h1234, 16'h0F0F, msg_q.pop_front());
                    check_eq("b2b_result", ap_return, exp);
                    check_eq("b2b_latency", 64'(c - acc_q.pop_front()), 64'd9);
                    n_res++;
                end
            end
            mv      = {4{16'(c)}} ^ 64'h0123_4567_89AB_CDEF;
            message = mv;
            if (ap_idle) begin
                if (last_acc >= 0) check_eq("b2b_spacing", 64'(c - last_acc), 64'd10);
                last_acc = c;
                acc_q.push_back(c);
                msg_q.push_back(mv);
            end
        end
        ap_start = 1'b0;
        check_eq("b2b_count", 64'(n_res), 64'd4);
        repeat (12) @(posedge ap_clk);

        // Random round trips, CBC then ECB
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 100; i++) begin
                k = 16'($urandom);
                v = 16'($urandom);
                m = {$urandom, $urandom};
                run_op(1'b0, (mode == 0), k, v, m, res, lat);
                exp = model(1'b0, (mode == 0), k, v, m);
                check_eq("rand_enc", res, exp);
                run_op(1'b1, (mode == 0), k, v, res, res2, lat);
                check_eq("rand_dec_model", res2, model(1'b1, (mode == 0), k, v, res));
                check_eq("rand_round_trip", res2, m);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
